counter_ctrl: RTL and testbench

Command sequencer that drives the control side of the `counter` block: `load_n`, `ce`, `up_down` and `data_load`. It accepts one command at a time over a valid/ready handshake: load a value, step up N, step down N, or no-op. It then issues the matching control pulses to the counter and watches the counter's `max_count`/`zero` status. It sits between the test sequence or system controller and the counter, and is the initiator for the interface that `counter` responds on.

---
 rtl/counter_ctrl_pkg.sv | 30 +++
 rtl/counter_ctrl.sv | 120 ++++++++++++
 tb/tb_counter_ctrl.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/counter_ctrl_pkg.sv
// Shared types and constants for the counter command sequencer.
// Pure declarations: no latency, no backpressure.
// The default data width is shared with the counter bench.
package counter_ctrl_pkg;

    // Default counter data width; also the width of the step-count argument.
    localparam int COUNTER_WIDTH = 4;

    // Command opcodes carried on cmd_op.
    typedef enum logic [1:0] {
        OP_LOAD = 2'd0,
        OP_UP   = 2'd1,
        OP_DOWN = 2'd2,
        OP_NOP  = 2'd3
    } op_t;

    // Sequencer FSM states.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    // True for opcodes that step the counter.
    function automatic logic op_is_step(input op_t op);
        return (op == OP_UP) || (op == OP_DOWN);
    endfunction

endpackage

// File: rtl/counter_ctrl.sv
// Command sequencer driving load_n/ce/up_down/data_load of the counter; optional saturation via COUNTER_CTRL_SAT_EN.
// Latency: LOAD done at T+2, UP/DOWN N done at T+N+1 (earlier stop + 1 on saturation), NOP or N=0 done at T+1.
// Backpressure: cmd_ready only in IDLE; a held cmd_valid waits and is taken on the first IDLE cycle.
module counter_ctrl
    import counter_ctrl_pkg::*;
#(
    parameter int WIDTH = COUNTER_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [WIDTH-1:0] cmd_arg,
    output logic             load_n,
    output logic             ce,
    output logic             up_down,
    output logic [WIDTH-1:0] data_load,
    input  logic [WIDTH-1:0] count_out,
    input  logic             max_count,
    input  logic             zero,
    output logic             busy,
    output logic             done,
    output logic             sat
);

    state_t           state;
    logic [WIDTH-1:0] rem;
    logic             accept;
    logic             limit_hit;
    op_t              op;

    assign op        = op_t'(cmd_op);
    assign accept    = cmd_valid && (state == ST_IDLE);

    // Status outputs are pure decodes of the registered state.
    assign cmd_ready = (state == ST_IDLE);
    assign busy      = (state != ST_IDLE);
    assign done      = (state == ST_DONE);

`ifdef COUNTER_CTRL_SAT_EN
    // Stop before stepping past all-ones (up) or zero (down); status reflects the previous step.
    assign limit_hit = (state == ST_RUN) && (up_down ? max_count : zero);
`else
    // Without saturation the counter simply wraps.
    assign limit_hit = 1'b0;
`endif

    // Counter controls decode from registered state only, so cmd_* never reaches them.
    assign load_n = (state != ST_LOAD);
    assign ce     = (state == ST_RUN) && !limit_hit;

    // Main sequencer: command capture, step countdown and state transitions.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            rem       <= '0;
            up_down   <= 1'b0;
            data_load <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        rem <= cmd_arg;
                        case (op)
                            OP_LOAD: begin
                                data_load <= cmd_arg;
                                state     <= ST_LOAD;
                            end
                            OP_UP, OP_DOWN: begin
                                up_down <= (op == OP_UP);
                                state   <= (cmd_arg != '0) ? ST_RUN : ST_DONE;
                            end
                            default: state <= ST_DONE;
                        endcase
                    end
                end
                ST_LOAD: state <= ST_DONE;
                ST_RUN: begin
                    if (limit_hit) begin
                        state <= ST_DONE;
                    end else begin
                        rem <= rem - WIDTH'(1);
                        if (rem == WIDTH'(1)) begin
                            state <= ST_DONE;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

`ifdef COUNTER_CTRL_SAT_EN
    // Sticky early-stop flag, cleared when the next command is taken.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sat <= 1'b0;
        end else if (accept) begin
            sat <= 1'b0;
        end else if (limit_hit) begin
            sat <= 1'b1;
        end
    end
`else
    assign sat = 1'b0;
`endif

    // Counter status is only observed here, never used for control beyond the limit check.
    a_excl: assert property (@(posedge clk) disable iff (!rst_n) !(ce && !load_n));
    a_max:  assert property (@(posedge clk) disable iff (!rst_n) max_count == (&count_out));
    a_zero: assert property (@(posedge clk) disable iff (!rst_n) zero == (count_out == '0));
    a_load: assert property (@(posedge clk) disable iff (!rst_n)
                (state == ST_DONE && $past(state) == ST_LOAD) |-> (count_out == data_load));

    // Only opcodes that step may enter RUN.
    a_run:  assert property (@(posedge clk) disable iff (!rst_n)
                (accept && !op_is_step(op)) |=> (state != ST_RUN));

endmodule

// File: tb/tb_counter_ctrl.sv
// Bench for counter_ctrl: behavioural counter, table of commands with expected results, scoreboard.
module tb_counter_ctrl;
    import counter_ctrl_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_op;
    logic [3:0] cmd_arg;
    logic       load_n, ce, up_down, busy, done, sat;
    logic [3:0] data_load;
    logic [3:0] count_q;
    logic [3:0] count_out;
    logic       max_count, zero;

    always #5 clk = ~clk;

    counter_ctrl #(.WIDTH(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_arg(cmd_arg),
        .load_n(load_n), .ce(ce), .up_down(up_down), .data_load(data_load),
        .count_out(count_out), .max_count(max_count), .zero(zero),
        .busy(busy), .done(done), .sat(sat)
    );

    // Behavioural counter that the sequencer drives.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n)      count_q <= 4'd0;
        else if (!load_n) count_q <= data_load;
        else if (ce)     count_q <= up_down ? count_q + 4'd1 : count_q - 4'd1;
    end
    assign count_out = count_q;
    assign max_count = &count_q;
    assign zero      = (count_q == 4'd0);

    typedef struct {
        op_t        op;
        logic [3:0] arg;
        int         lat;
        int         n_ce;
        int         n_ld;
        logic [3:0] cnt;
        logic       sat;
        logic       ud;
    } vec_t;

    int   checks = 0;
    int   errors = 0;
    vec_t sb[$];
    vec_t tbl[$];
    vec_t e;

    function automatic vec_t mk(op_t op, logic [3:0] arg, int lat, int n_ce, int n_ld,
                                logic [3:0] cnt, logic s, logic ud);
        vec_t v;
        v.op = op; v.arg = arg; v.lat = lat; v.n_ce = n_ce; v.n_ld = n_ld;
        v.cnt = cnt; v.sat = s; v.ud = ud;
        return v;
    endfunction

    function automatic void chk(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endfunction

    // Monitor: counts cycles and pulses per command, pops the scoreboard on done.
    int ncyc = 0, cyc = 0, ce_n = 0, ld_n = 0;
    int total_ce = 0, total_done = 0, last_done = 0, last_acc = 0;
    bit in_cmd = 0, post_done = 0;

    always @(negedge clk) begin
        ncyc++;
        if (!rst_n) begin
            in_cmd = 0;
            post_done = 0;
            sb.delete();
        end else begin
            chk("ce/load_n exclusive", int'(ce && !load_n), 0);
            if (ce) total_ce++;
            if (done) total_done++;
            if (post_done) begin
                chk("ready after done", int'(cmd_ready), 1);
                chk("done single cycle", int'(done), 0);
                post_done = 0;
            end else if (in_cmd) begin
                cyc++;
                if (ce) ce_n++;
                if (!load_n) ld_n++;
                if (done) begin
                    if (sb.size() == 0) begin
                        chk("scoreboard underflow", 0, 1);
                    end else begin
                        e = sb.pop_front();
                        chk("done latency", cyc, e.lat);
                        chk("ce cycles", ce_n, e.n_ce);
                        chk("load_n cycles", ld_n, e.n_ld);
                        chk("count_out", int'(count_out), int'(e.cnt));
                        chk("sat", int'(sat), int'(e.sat));
                        chk("up_down", int'(up_down), int'(e.ud));
                        chk("busy at done", int'(busy), 1);
                        if (e.op == OP_LOAD) chk("data_load", int'(data_load), int'(e.arg));
                    end
                    in_cmd = 0;
                    post_done = 1;
                    last_done = ncyc;
                end else if (cyc > 40) begin
                    chk("done timeout", 0, 1);
                    in_cmd = 0;
                end
            end else if (done) begin
                chk("spurious done", 1, 0);
            end
            if (cmd_valid && cmd_ready) begin
                in_cmd = 1;
                cyc = 0;
                ce_n = 0;
                ld_n = 0;
                last_acc = ncyc;
            end
        end
    end

    // Present a command, hold it until taken, then queue its expected result.
    task automatic send(input vec_t v);
        int waited = 0;
        cmd_op = v.op;
        cmd_arg = v.arg;
        cmd_valid = 1'b1;
        do begin
            @(negedge clk);
            waited++;
        end while (!cmd_ready && waited < 100);
        if (!cmd_ready) begin
            chk("accept timeout", 0, 1);
            cmd_valid = 1'b0;
            return;
        end
        sb.push_back(v);
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
    endtask

    initial begin
        int ce0, d0, w;
        rst_n = 1'b0;
        cmd_valid = 1'b0;
        cmd_op = 2'd0;
        cmd_arg = 4'd0;
        #1;
        chk("rst load_n", int'(load_n), 1);
        chk("rst ce", int'(ce), 0);
        chk("rst up_down", int'(up_down), 0);
        chk("rst data_load", int'(data_load), 0);
        chk("rst done", int'(done), 0);
        chk("rst sat", int'(sat), 0);
        chk("rst busy", int'(busy), 0);
        chk("rst cmd_ready", int'(cmd_ready), 1);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;

        tbl.push_back(mk(OP_LOAD, 4'hA, 2, 0, 1, 4'hA, 0, 0));
        tbl.push_back(mk(OP_LOAD, 4'h5, 2, 0, 1, 4'h5, 0, 0));
        tbl.push_back(mk(OP_UP,   4'd3, 4, 3, 0, 4'h8, 0, 1));
        tbl.push_back(mk(OP_LOAD, 4'hE, 2, 0, 1, 4'hE, 0, 1));
`ifdef COUNTER_CTRL_SAT_EN
        tbl.push_back(mk(OP_UP,   4'd5, 3, 1, 0, 4'hF, 1, 1));
`else
        tbl.push_back(mk(OP_UP,   4'd5, 6, 5, 0, 4'h3, 0, 1));
`endif
        tbl.push_back(mk(OP_LOAD, 4'h2, 2, 0, 1, 4'h2, 0, 1));
        tbl.push_back(mk(OP_DOWN, 4'd0, 1, 0, 0, 4'h2, 0, 0));
        tbl.push_back(mk(OP_NOP,  4'd0, 1, 0, 0, 4'h2, 0, 0));
`ifdef COUNTER_CTRL_SAT_EN
        tbl.push_back(mk(OP_DOWN, 4'd3, 4, 2, 0, 4'h0, 1, 0));
`else
        tbl.push_back(mk(OP_DOWN, 4'd3, 4, 3, 0, 4'hF, 0, 0));
`endif
        tbl.push_back(mk(OP_LOAD, 4'h0, 2, 0, 1, 4'h0, 0, 0));
        tbl.push_back(mk(OP_UP,   4'hF, 16, 15, 0, 4'hF, 0, 1));
`ifdef COUNTER_CTRL_SAT_EN
        tbl.push_back(mk(OP_UP,   4'd1, 2, 0, 0, 4'hF, 1, 1));
`else
        tbl.push_back(mk(OP_UP,   4'd1, 2, 1, 0, 4'h0, 0, 1));
`endif
        foreach (tbl[i]) send(tbl[i]);

        // Held valid: DOWN is presented while UP is running and must be taken right after UP's done.
        send(mk(OP_LOAD, 4'h8, 2, 0, 1, 4'h8, 0, 1));
        send(mk(OP_UP,   4'd3, 4, 3, 0, 4'hB, 0, 1));
        send(mk(OP_DOWN, 4'd4, 5, 4, 0, 4'h7, 0, 0));
        chk("held accept cycle", last_acc, last_done + 1);

        // Reset in the second RUN cycle of UP 6.
        send(mk(OP_UP, 4'd6, 7, 6, 0, 4'hD, 0, 1));
        @(posedge clk);
        #1;
        chk("ce before reset", int'(ce), 1);
        chk("busy before reset", int'(busy), 1);
        rst_n = 1'b0;
        #1;
        chk("mid-run rst ce", int'(ce), 0);
        chk("mid-run rst load_n", int'(load_n), 1);
        chk("mid-run rst busy", int'(busy), 0);
        chk("mid-run rst done", int'(done), 0);
        chk("mid-run rst up_down", int'(up_down), 0);
        chk("mid-run rst cmd_ready", int'(cmd_ready), 1);
        cmd_op = OP_UP;
        cmd_arg = 4'd3;
        cmd_valid = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        ce0 = total_ce;
        d0 = total_done;
        rst_n = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        chk("no ce after reset", total_ce, ce0);
        chk("no done after reset", total_done, d0);
        chk("ready after reset", int'(cmd_ready), 1);
        chk("idle after reset", int'(busy), 0);
        send(mk(OP_LOAD, 4'h3, 2, 0, 1, 4'h3, 0, 0));

        w = 0;
        while ((sb.size() != 0 || in_cmd) && w < 200) begin
            @(posedge clk);
            w++;
        end
        chk("drain scoreboard", sb.size(), 0);
        repeat (2) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
